// File: rtl/strobe_edge_capture.sv
// strobe_edge_capture
//   Captures in_a into a small FIFO on each rising edge of the strobe in_b.
//   Everything runs on clk. The strobe is not used as a clock. A registered
//   copy of in_b (b_q) finds 0->1 transitions, and each one acts as a
//   one-cycle write enable. Consumers drain the FIFO with a valid/ready
//   handshake.
//
// Ports
//   clk        sole clock, all flops on posedge
//   rst        asynchronous, active-low reset
//   in_a       data sampled on a detected strobe edge
//   in_b       strobe, synchronous to clk
//   out_data   FIFO head (zero while empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts head when out_valid & out_ready
//   ovf_clr    clears the sticky overflow flag
//   overflow   sticky: an edge was dropped because the FIFO was full
//   cap_count  number of accepted captures, wraps

module strobe_edge_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_a,
    input  logic              in_b,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              ovf_clr,
    output logic              overflow,
    output logic [CNT_W-1:0]  cap_count
);

    localparam int AW = $clog2(DEPTH);

    logic              b_q;
    logic              strobe_edge;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              empty;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              drop;

    // b_q resets high, so a strobe that is already high at reset release
    // does not count as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_q <= 1'b1;
        end else begin
            b_q <= in_b;
        end
    end

    assign strobe_edge = in_b & ~b_q;

    // Pointers carry one extra wrap bit so that full and empty differ.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A pop from a full FIFO frees the slot that this cycle's push uses.
    assign push_ok   = strobe_edge & (~full | pop);
    assign drop      = strobe_edge & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // The storage needs no reset. The output is gated while the FIFO is
    // empty, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= in_a;
        end
    end

    assign out_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // If a drop and a clear happen in the same cycle, the set wins so that
    // the drop is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_count <= '0;
        end else if (push_ok) begin
            cap_count <= cap_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_strobe_edge_capture.sv
// tb_strobe_edge_capture
//   Directed bench for strobe_edge_capture. Each scenario task drives its
//   stimulus and checks against hand-computed values. cap_count is built
//   8 bits wide here so that its wrap can be reached in a short run.

module tb_strobe_edge_capture;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_a;
    logic              in_b;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              ovf_clr;
    logic              overflow;
    logic [CNT_W-1:0]  cap_count;

    int checks = 0;
    int passes = 0;

    strobe_edge_capture #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ovf_clr  (ovf_clr),
        .overflow (overflow),
        .cap_count(cap_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a posedge. Outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_a      = '0;
        in_b      = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    // One strobe pulse: the edge is seen at the first posedge.
    task automatic pulse(input logic [DATA_W-1:0] d);
        in_a = d;
        in_b = 1'b1;
        tick();
        in_b = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_a      = 8'h3C;
        in_b      = 1'b1;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || overflow !== 1'b0 || cap_count !== 8'd0)
            $display("FAIL reset_state: valid=%b data=%h ovf=%b cnt=%0d, expected 0/00/0/0",
                     out_valid, out_data, overflow, cap_count);
        else passes++;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || cap_count !== 8'd0)
            $display("FAIL reset_release_b_high: valid=%b cnt=%0d, expected 0/0",
                     out_valid, cap_count);
        else passes++;
    endtask

    task automatic test_single_capture();
        do_reset();
        in_a = 8'hA5;
        in_b = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || cap_count !== 8'd1)
            $display("FAIL single_capture: valid=%b data=%h cnt=%0d, expected 1/a5/1",
                     out_valid, out_data, cap_count);
        else passes++;
        in_a = 8'h11;
        in_b = 1'b0;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5)
            $display("FAIL single_hold: valid=%b data=%h, expected 1/a5", out_valid, out_data);
        else passes++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || cap_count !== 8'd1)
            $display("FAIL single_pop: valid=%b cnt=%0d, expected 0/1", out_valid, cap_count);
        else passes++;
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] exp_q [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_reset();
        for (int i = 1; i <= 5; i++) pulse(DATA_W'(i));
        checks++;
        if (overflow !== 1'b1 || cap_count !== 8'd4 || out_data !== 8'd1)
            $display("FAIL overflow_set: ovf=%b cnt=%0d head=%h, expected 1/4/01",
                     overflow, cap_count, out_data);
        else passes++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[i])
                $display("FAIL drain_order[%0d]: valid=%b data=%h, expected 1/%h",
                         i, out_valid, out_data, exp_q[i]);
            else passes++;
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1)
            $display("FAIL drain_empty: valid=%b ovf=%b, expected 0/1", out_valid, overflow);
        else passes++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0)
            $display("FAIL ovf_clear: ovf=%b, expected 0", overflow);
        else passes++;
    endtask

    task automatic test_set_wins();
        do_reset();
        for (int i = 0; i < 4; i++) pulse(8'h50 + DATA_W'(i));
        in_a    = 8'h99;
        in_b    = 1'b1;
        ovf_clr = 1'b1;
        tick();
        in_b    = 1'b0;
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1 || cap_count !== 8'd4 || out_data !== 8'h50)
            $display("FAIL drop_vs_clear: ovf=%b cnt=%0d head=%h, expected 1/4/50",
                     overflow, cap_count, out_data);
        else passes++;
    endtask

    task automatic test_full_push_pop();
        logic [DATA_W-1:0] exp_q [4] = '{8'h20, 8'h30, 8'h40, 8'h77};
        do_reset();
        pulse(8'h10);
        pulse(8'h20);
        pulse(8'h30);
        pulse(8'h40);
        in_a      = 8'h77;
        in_b      = 1'b1;
        out_ready = 1'b1;
        tick();
        in_b      = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0 || cap_count !== 8'd5 || out_data !== 8'h20)
            $display("FAIL full_push_pop: ovf=%b cnt=%0d head=%h, expected 0/5/20",
                     overflow, cap_count, out_data);
        else passes++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[i])
                $display("FAIL full_drain[%0d]: valid=%b data=%h, expected 1/%h",
                         i, out_valid, out_data, exp_q[i]);
            else passes++;
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL full_drain_empty: valid=%b, expected 0", out_valid);
        else passes++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        // in_b 1-0-1 gives two edges. The long high after that gives no more.
        in_a = 8'hC1; in_b = 1'b1; tick();
        in_a = 8'hEE; in_b = 1'b0; tick();
        in_a = 8'hC2; in_b = 1'b1; tick();
        in_a = 8'hC3; repeat (3) tick();
        in_b = 1'b0; tick();
        checks++;
        if (cap_count !== 8'd2 || out_data !== 8'hC1)
            $display("FAIL back_to_back: cnt=%0d head=%h, expected 2/c1", cap_count, out_data);
        else passes++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hC2)
            $display("FAIL back_to_back_second: valid=%b data=%h, expected 1/c2",
                     out_valid, out_data);
        else passes++;
    endtask

    task automatic test_count_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < (1 << CNT_W) - 1; i++) pulse(DATA_W'(i));
        checks++;
        if (cap_count !== 8'hFF || out_valid !== 1'b0)
            $display("FAIL count_preload: cnt=%0d valid=%b, expected 255/0", cap_count, out_valid);
        else passes++;
        pulse(8'h5A);
        checks++;
        if (cap_count !== 8'd0 || overflow !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL count_wrap: cnt=%0d ovf=%b valid=%b, expected 0/0/0",
                     cap_count, overflow, out_valid);
        else passes++;
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse(8'h01);
        pulse(8'h02);
        pulse(8'h03);
        checks++;
        if (out_valid !== 1'b1 || cap_count !== 8'd3)
            $display("FAIL pre_reset_queue: valid=%b cnt=%0d, expected 1/3", out_valid, cap_count);
        else passes++;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || cap_count !== 8'd0 || out_data !== 8'h00)
            $display("FAIL async_reset: valid=%b ovf=%b cnt=%0d data=%h, expected 0/0/0/00",
                     out_valid, overflow, cap_count, out_data);
        else passes++;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_overflow();
        test_set_wins();
        test_full_push_pop();
        test_back_to_back();
        test_count_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
